// File: rtl/game_flow_sequencer.sv
// Battle-screen turn sequencer (MENU -> PLAYER -> ENEMY rounds, WIN) plus the
// game-over animation timeline (idle, heart split, heart fall, text fade).
module game_flow_sequencer #(
    parameter int unsigned IDLE_CYCLES  = 65_000_000,
    parameter int unsigned SPLIT_CYCLES = 130_000_000,
    parameter int unsigned FALL_CYCLES  = 65_000_000,
    parameter int unsigned FADE_FRAMES  = 32,
    parameter int unsigned MAX_ROUNDS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        menu_done,
    input  logic        player_done,
    input  logic        enemy_done,
    input  logic        game_over_in,
    input  logic        new_frame,
    input  logic        restart_in,
    output logic [3:0]  state_out,
    output logic [2:0]  phase_out,
    output logic        round_rst_out,
    output logic        divided_out,
    output logic        fall_valid_out,
    output logic [11:0] font_color_out,
    output logic [7:0]  round_count_out
);

    typedef enum logic [3:0] {
        ST_MENU   = 4'b0000,
        ST_PLAYER = 4'b0001,
        ST_ENEMY  = 4'b1000,
        ST_WIN    = 4'b0010,
        ST_OVER   = 4'b1111
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_SPLIT = 2'd1,
        PH_FALL  = 2'd2,
        PH_FADE  = 2'd3
    } phase_t;

    localparam int unsigned MAX_AB  = (IDLE_CYCLES > SPLIT_CYCLES) ? IDLE_CYCLES : SPLIT_CYCLES;
    localparam int unsigned MAX_DUR = (MAX_AB > FALL_CYCLES) ? MAX_AB : FALL_CYCLES;
    localparam int unsigned TIMER_W = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;
    localparam int unsigned FRAME_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

    localparam logic [TIMER_W-1:0] IDLE_LAST  = TIMER_W'(IDLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SPLIT_LAST = TIMER_W'(SPLIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] FALL_LAST  = TIMER_W'(FALL_CYCLES - 1);
    localparam logic [FRAME_W-1:0] FADE_LAST  = FRAME_W'(FADE_FRAMES - 1);

    state_t               state_q, state_d;
    phase_t               phase_q, phase_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [3:0]           grey_q, grey_d;
    logic [7:0]           rounds_q, rounds_d;
    logic                 divided_q, divided_d;
    logic                 fall_q, fall_d;
    logic                 round_rst_q, round_rst_d;
    logic                 menu_q, player_q, enemy_q, over_q;

    logic menu_rise, player_rise, enemy_rise, over_rise;
    logic restart_ok;
    logic last_round;

    assign menu_rise   = menu_done    & ~menu_q;
    assign player_rise = player_done  & ~player_q;
    assign enemy_rise  = enemy_done   & ~enemy_q;
    assign over_rise   = game_over_in & ~over_q;

    assign restart_ok = restart_in &&
                        ((state_q == ST_OVER && phase_q == PH_FADE && grey_q == 4'hF) ||
                         state_q == ST_WIN);
    assign last_round = ({1'b0, rounds_q} + 9'd1) == 9'(MAX_ROUNDS);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_MENU;
            phase_q     <= PH_IDLE;
            timer_q     <= '0;
            frame_q     <= '0;
            grey_q      <= '0;
            rounds_q    <= '0;
            divided_q   <= 1'b0;
            fall_q      <= 1'b0;
            round_rst_q <= 1'b0;
            menu_q      <= 1'b0;
            player_q    <= 1'b0;
            enemy_q     <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            timer_q     <= timer_d;
            frame_q     <= frame_d;
            grey_q      <= grey_d;
            rounds_q    <= rounds_d;
            divided_q   <= divided_d;
            fall_q      <= fall_d;
            round_rst_q <= round_rst_d;
            menu_q      <= menu_done;
            player_q    <= player_done;
            enemy_q     <= enemy_done;
            over_q      <= game_over_in;
        end
    end

    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        timer_d     = timer_q;
        frame_d     = frame_q;
        grey_d      = grey_q;
        rounds_d    = rounds_q;
        divided_d   = divided_q;
        fall_d      = fall_q;
        round_rst_d = 1'b0;

        if (restart_ok) begin
            state_d     = ST_MENU;
            phase_d     = PH_IDLE;
            timer_d     = '0;
            frame_d     = '0;
            grey_d      = '0;
            rounds_d    = '0;
            divided_d   = 1'b0;
            fall_d      = 1'b0;
            round_rst_d = 1'b1;
        end else if (state_q == ST_OVER) begin
            unique case (phase_q)
                PH_IDLE: begin
                    if (timer_q == IDLE_LAST) begin
                        phase_d   = PH_SPLIT;
                        timer_d   = '0;
                        divided_d = 1'b1;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                PH_SPLIT: begin
                    if (timer_q == SPLIT_LAST) begin
                        phase_d = PH_FALL;
                        timer_d = '0;
                        fall_d  = 1'b1;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                PH_FALL: begin
                    if (timer_q == FALL_LAST) begin
                        phase_d = PH_FADE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                PH_FADE: begin
                    if (new_frame) begin
                        if (frame_q == FADE_LAST) begin
                            frame_d = '0;
                            if (grey_q != 4'hF) grey_d = grey_q + 4'd1;
                        end else begin
                            frame_d = frame_q + FRAME_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end else if (state_q != ST_WIN) begin
            // Only the highest-priority rise is considered; it may still be ignored.
            if (over_rise) begin
                state_d   = ST_OVER;
                phase_d   = PH_IDLE;
                timer_d   = '0;
                frame_d   = '0;
                grey_d    = '0;
                divided_d = 1'b0;
                fall_d    = 1'b0;
            end else if (enemy_rise) begin
                if (state_q == ST_ENEMY) begin
                    rounds_d = (rounds_q == 8'hFF) ? rounds_q : rounds_q + 8'd1;
                    if (last_round) begin
                        state_d = ST_WIN;
                    end else begin
                        state_d     = ST_MENU;
                        round_rst_d = 1'b1;
                    end
                end
            end else if (player_rise) begin
                if (state_q == ST_PLAYER) state_d = ST_ENEMY;
            end else if (menu_rise) begin
                if (state_q == ST_MENU) state_d = ST_PLAYER;
            end
        end
    end

    assign state_out       = state_q;
    assign phase_out       = {1'b0, phase_q};
    assign round_rst_out   = round_rst_q;
    assign divided_out     = divided_q;
    assign fall_valid_out  = fall_q;
    assign font_color_out  = {grey_q, grey_q, grey_q};
    assign round_count_out = rounds_q;

endmodule
